// File: rtl/tinker_mem_responder_if.sv
// Request/response bundle between the Tinker core initiators
// and the memory responder.
interface tinker_mem_responder_if;
   logic        if_req_valid;
   logic [63:0] if_req_addr;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_inst;
   logic        if_rsp_err;
   logic        d_req_valid;
   logic        d_req_we;
   logic [63:0] d_req_addr;
   logic [63:0] d_req_wdata;
   logic        d_req_ready;
   logic        d_rsp_valid;
   logic [63:0] d_rsp_rdata;
   logic        d_rsp_err;

   modport master (
      output if_req_valid, if_req_addr,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      input  if_req_ready, if_rsp_valid, if_rsp_inst, if_rsp_err,
      input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
   );

   modport slave (
      input  if_req_valid, if_req_addr,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      output if_req_ready, if_rsp_valid, if_rsp_inst, if_rsp_err,
      output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
   );
endinterface

// File: rtl/tinker_mem_responder.sv
// Multi-cycle byte-addressed memory responder serving fetch and
// data ports, one outstanding request at a time.
module tinker_mem_responder #(
   parameter int MEM_BYTES = 524288,
   parameter int LATENCY   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   tinker_mem_responder_if.slave bus,
   output logic                  busy
);

   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q;
   logic          port_d_q;
   logic          we_q;
   logic [63:0]   addr_q;
   logic [63:0]   wdata_q;
   logic          acc_d, acc_if, access;
   logic          in_range, do_store;
   logic [64:0]   last_byte;
   logic [AW-1:0] base;

   logic [7:0]    mem [MEM_BYTES];

   // Next state, readiness and accept decode; data beats fetch.
   always_comb begin
      state_d          = state_q;
      bus.d_req_ready  = 1'b0;
      bus.if_req_ready = 1'b0;
      acc_d            = 1'b0;
      acc_if           = 1'b0;
      access           = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.d_req_ready  = 1'b1;
            bus.if_req_ready = !bus.d_req_valid;
            acc_d  = bus.d_req_valid;
            acc_if = bus.if_req_valid && !bus.d_req_valid;
            if (acc_d || acc_if) state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Range check in 65 bits so a high address cannot wrap.
   always_comb begin
      last_byte = {1'b0, addr_q} + (port_d_q ? 65'd7 : 65'd3);
      in_range  = last_byte < 65'(MEM_BYTES);
      base      = addr_q[AW-1:0];
      do_store  = access && port_d_q && we_q && in_range;
   end

   // State, latency counter and captured request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         port_d_q <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 64'd0;
         wdata_q  <= 64'd0;
      end else begin
         state_q <= state_d;
         if (acc_d || acc_if) begin
            port_d_q <= acc_d;
            we_q     <= acc_d && bus.d_req_we;
            addr_q   <= acc_d ? bus.d_req_addr : bus.if_req_addr;
            wdata_q  <= bus.d_req_wdata;
            cnt_q    <= 4'(LATENCY - 1);
         end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   // Byte array write; contents survive reset.
   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int i = 0; i < 8; i++)
            mem[base + AW'(i)] <= wdata_q[8*i +: 8];
      end
   end

   // Registered response data, held until the next response per port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.d_rsp_rdata <= 64'd0;
         bus.d_rsp_err   <= 1'b0;
         bus.if_rsp_inst <= 32'd0;
         bus.if_rsp_err  <= 1'b0;
      end else if (access) begin
         if (port_d_q) begin
            bus.d_rsp_err <= !in_range;
            for (int i = 0; i < 8; i++)
               bus.d_rsp_rdata[8*i +: 8] <= (in_range && !we_q) ?
                  mem[base + AW'(i)] : 8'h00;
         end else begin
            bus.if_rsp_err <= !in_range;
            for (int i = 0; i < 4; i++)
               bus.if_rsp_inst[8*i +: 8] <= in_range ?
                  mem[base + AW'(i)] : 8'h00;
         end
      end
   end

   assign bus.d_rsp_valid  = (state_q == RESP) && port_d_q;
   assign bus.if_rsp_valid = (state_q == RESP) && !port_d_q;
   assign busy             = (state_q != IDLE);

endmodule
